// File: rtl/div8_seq_if.sv
// Request/result bundle for the 8-bit sequential divider.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy/done and never stalls the divider.
interface div8_seq_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    // Requester side: issues operands, observes status and results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div8_seq.sv
// 8-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done is high in the cycle after the 9th edge from accept (after the accept edge for divisor 0).
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module div8_seq (
    input  logic       clk,
    input  logic       rst,
    div8_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    // Dividend bits shift out at the MSB while quotient bits shift in at the LSB;
    // after eight steps this register holds the quotient.
    logic [7:0] shf_q,   shf_d;
    logic [7:0] dvs_q,   dvs_d;
    logic [7:0] rem_q,   rem_d;
    logic       dbz_q,   dbz_d;

    logic       accept;
    logic [8:0] trial;
    logic       ge;
    logic [7:0] diff;

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shf_q   <= 8'd0;
            dvs_q   <= 8'd0;
            rem_q   <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shf_q   <= shf_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state: zero divisor short-circuits straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (bus.divisor == 8'd0) ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One restoring step per CALC cycle; operands latched on accept
    always_comb begin
        // Trial is 9 bits so the shifted-in bit never overflows the compare.
        trial = {rem_q, shf_q[7]};
        ge    = (trial >= {1'b0, dvs_q});
        // When ge holds the true difference is < divisor <= 255, so the low
        // 8 bits of the subtraction are exact.
        diff  = trial[7:0] - dvs_q;

        cnt_d = cnt_q;
        shf_d = shf_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        dbz_d = dbz_q;

        if (accept) begin
            cnt_d = 3'd0;
            dvs_d = bus.divisor;
            dbz_d = 1'b0;
            rem_d = 8'd0;
            shf_d = bus.dividend;
            if (bus.divisor == 8'd0) begin
                dbz_d = 1'b1;
                shf_d = 8'hFF;
                rem_d = bus.dividend;
            end
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 3'd1;
            rem_d = ge ? diff : trial[7:0];
            shf_d = {shf_q[6:0], ge};
        end
    end

    // Status is a pure decode of the state; results come straight from the flops
    always_comb begin
        bus.busy        = (state_q == CALC);
        bus.done        = (state_q == DONE);
        bus.quotient    = shf_q;
        bus.remainder   = rem_q;
        bus.div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: table vectors, random vectors and
// hand-written corner sequences, with a scoreboard checked on each done pulse.
module tb_div8_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div8_seq_if bus ();

    div8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request
    exp_t e;
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quotient",    bus.quotient,    e.q);
                check("remainder",   bus.remainder,   e.r);
                check("div_by_zero", bus.div_by_zero, e.z);
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    // Drive a request for the coming edge and record what it must produce
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r, input logic z);
        exp_t x;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        x.q = q;
        x.r = r;
        x.z = z;
        sb.push_back(x);
    endtask

    // Wait for done, counting edges after the accept edge
    task automatic wait_for_done(input int from, output int cnt);
        cnt = from;
        while (bus.done !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    // Take the accept edge, check immediate status, then wait out the latency
    task automatic wait_done(input logic zero);
        int cnt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (zero) begin
            check("busy_after_accept_dbz", bus.busy, 0);
            check("done_after_accept_dbz", bus.done, 1);
        end else begin
            check("busy_after_accept", bus.busy, 1);
            check("done_after_accept", bus.done, 0);
        end
        wait_for_done(0, cnt);
        check("latency", cnt, zero ? 0 : 8);
    endtask

    vec_t tbl[10];

    initial begin
        int   cnt;
        int   nd0;
        logic [7:0] ra, rb;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        tbl[1] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1};
        tbl[2] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        tbl[3] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        tbl[4] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        tbl[5] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
        tbl[6] = '{8'd0,   8'd0,   8'hFF,  8'd0,  1'b1};
        tbl[7] = '{8'd128, 8'd2,   8'd64,  8'd0,  1'b0};
        tbl[8] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
        tbl[9] = '{8'd200, 8'd13,  8'd15,  8'd5,  1'b0};

        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy",      bus.busy,        0);
        check("rst_done",      bus.done,        0);
        check("rst_quotient",  bus.quotient,    0);
        check("rst_remainder", bus.remainder,   0);
        check("rst_dbz",       bus.div_by_zero, 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, then confirm results hold after the done pulse
        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);
            wait_done(tbl[i].b == 8'd0);
            @(posedge clk);
            #1;
            check("done_one_cycle", bus.done,        0);
            check("hold_quotient",  bus.quotient,    tbl[i].q);
            check("hold_remainder", bus.remainder,   tbl[i].r);
            check("hold_dbz",       bus.div_by_zero, tbl[i].z);
        end

        // Random vectors against an arithmetic model
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'd0)
                start_op(ra, rb, 8'hFF, ra, 1'b1);
            else
                start_op(ra, rb, ra / rb, ra % rb, 1'b0);
            wait_done(rb == 8'd0);
            @(posedge clk);
            #1;
        end

        // start during CALC is ignored; operand changes mid-run have no effect
        nd0 = n_done;
        start_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom_range(0, 255));
        bus.divisor  = 8'($urandom_range(0, 255));
        wait_for_done(4, cnt);
        check("ignored_start_latency", cnt, 8);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("ignored_start_single_done", n_done - nd0, 1);

        // Reset in the middle of an operation aborts it without done
        start_op(8'd77, 8'd4, 8'd19, 8'd1, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",      bus.busy,        0);
        check("abort_done",      bus.done,        0);
        check("abort_quotient",  bus.quotient,    0);
        check("abort_remainder", bus.remainder,   0);
        check("abort_dbz",       bus.div_by_zero, 0);
        sb.delete();
        rst = 1'b0;
        nd0 = n_done;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_done", n_done - nd0, 0);
        start_op(8'd77, 8'd4, 8'd19, 8'd1, 1'b0);
        wait_done(1'b0);
        @(posedge clk);
        #1;

        // Back-to-back: new start issued in the DONE cycle
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        wait_done(1'b0);
        start_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
        wait_done(1'b0);
        start_op(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);
        wait_done(1'b1);
        @(posedge clk);
        #1;
        check("final_done_low", bus.done, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div8_seq.md
DIV8_SEQ -- requirements
Module: div8_seq

Interface
REQ-001 Parameter: none; operand width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL change only on the rising edge.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005 dividend  input  8  unsigned numerator; sampled only on an accepted start.
REQ-006 divisor  input  8  unsigned denominator; sampled only on an accepted start.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse marking that the results are valid.
REQ-009 quotient  output  8  unsigned quotient.
REQ-010 remainder  output  8  unsigned remainder.
REQ-011 div_by_zero  output  1  high with the results when the latched divisor was 0.

Function
REQ-012 FSM states SHALL be exactly IDLE, CALC and DONE; no other state SHALL be reachable.
REQ-013 Accept rule: start=1 at an edge while the state is IDLE or DONE SHALL latch dividend and divisor, clear div_by_zero, and clear the working remainder.
REQ-014 After an accepted start with divisor!=0, the next state SHALL be CALC with the step counter at 0.
REQ-015 After an accepted start with divisor==0, the next state SHALL be DONE.
  - quotient=8'hFF, remainder=dividend, div_by_zero=1.
REQ-016 In CALC, each edge SHALL perform one restoring step, MSB first.
  - Trial value = {rem[7:0], next dividend bit}, computed at 9 bits.
  - If trial >= divisor: rem = trial - divisor, quotient bit = 1.
  - Else: rem = trial, quotient bit = 0.
REQ-017 The remainder datapath SHALL be 9 bits wide so the trial value never overflows; the stored remainder SHALL always be < divisor.
REQ-018 The step counter SHALL increment once per CALC edge; on the edge that performs step 7 (the 8th step), the state SHALL go to DONE.
REQ-019 Latency: with the start accepted at edge E0, done SHALL be high for the cycle following E8 (divisor!=0) or following E0 (divisor==0).
REQ-020 busy SHALL be 1 exactly while the state is CALC.
REQ-021 done SHALL be 1 exactly while the state is DONE; DONE SHALL last one cycle.
  - DONE goes to IDLE, or to CALC/DONE if start=1 at that edge (back-to-back).
REQ-022 quotient, remainder and div_by_zero SHALL hold their final values after DONE until the next accepted start.
REQ-023 start=1 while in CALC SHALL be ignored, with no effect on the operation or the operands.
REQ-024 Inputs dividend/divisor changing during CALC SHALL NOT affect the result.
REQ-025 Result SHALL satisfy dividend == quotient*divisor + remainder for every divisor!=0, including these boundaries:
  - dividend=0
  - dividend<divisor
  - divisor=1
  - 255/255

Reset
REQ-026 rst=1 at an edge SHALL force the state to IDLE and clear the step counter.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-027 rst SHALL take priority over start and SHALL abort an in-progress division with no done pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-029 Basic: start with 100/7 at E0 -> busy high E0..E8, done pulse after E8, quotient=14, remainder=2, div_by_zero=0.
REQ-030 Zero divisor: start with 37/0 -> done after E0, busy never high, quotient=8'hFF, remainder=37, div_by_zero=1.
REQ-031 Boundaries: 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 255/255 -> q=1, r=0; 0/3 -> q=0, r=0.
REQ-032 Ignored start: start 200/13, then pulse start with 9/3 at E4 -> result q=15, r=5 at the normal time, no second operation.
REQ-033 Reset mid-op: start 77/4, assert rst at E3 -> all outputs 0 next cycle, no done pulse; a later 77/4 gives q=19, r=1.
REQ-034 Back-to-back: start=1 in the DONE cycle with 50/6 -> new operation accepted, next done pulse 8 edges later, q=8, r=2.
